// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT defaults plus rounding and saturation helpers
package fft_pkg;

    localparam int DATA_WIDTH_DEF = 21;
    localparam int FRAC_BITS_DEF  = 15;
    localparam int ACC_W          = 64;

    typedef logic signed [ACC_W-1:0] acc_t;

    // Round-half-up arithmetic right shift; a zero shift passes the value through.
    function automatic acc_t round_shift(input acc_t x, input int sh);
        acc_t r;
        r = x;
        if (sh > 0) begin
            r = x + (acc_t'(1) <<< (sh - 1));
        end
        return r >>> sh;
    endfunction

    function automatic logic sat_hit(input acc_t x, input int w);
        acc_t hi;
        acc_t lo;
        hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
        lo = -(acc_t'(1) <<< (w - 1));
        return (x > hi) || (x < lo);
    endfunction

    function automatic acc_t saturate(input acc_t x, input int w);
        acc_t hi;
        acc_t lo;
        hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
        lo = -(acc_t'(1) <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/cmult_conj.sv
// rtl/cmult_conj.sv - registered full-precision complex multiply, optional conj(W)
module cmult_conj #(
    parameter int DW = 21,
    parameter int XW = DW + 1,
    parameter int PW = XW + DW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          inv_i,
    input  logic [XW-1:0] x_re_i,
    input  logic [XW-1:0] x_im_i,
    input  logic [DW-1:0] w_re_i,
    input  logic [DW-1:0] w_im_i,
    output logic [PW-1:0] p_re_o,
    output logic [PW-1:0] p_im_o
);

    localparam int MW = XW + DW;

    logic signed [XW-1:0] xr, xi;
    logic signed [DW-1:0] wr, wi;
    logic signed [MW-1:0] rr, ii, ir, ri;
    logic signed [PW-1:0] re_d, im_d;

    assign xr = x_re_i;
    assign xi = x_im_i;
    assign wr = w_re_i;
    assign wi = w_im_i;

    assign rr = MW'(xr) * MW'(wr);
    assign ii = MW'(xi) * MW'(wi);
    assign ir = MW'(xi) * MW'(wr);
    assign ri = MW'(xr) * MW'(wi);

    // Conjugating W only flips the sign of the cross terms involving wi.
    always_comb begin
        re_d = inv_i ? (PW'(rr) + PW'(ii)) : (PW'(rr) - PW'(ii));
        im_d = inv_i ? (PW'(ir) - PW'(ri)) : (PW'(ir) + PW'(ri));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_re_o <= '0;
            p_im_o <= '0;
        end else if (en_i) begin
            p_re_o <= re_d;
            p_im_o <= im_d;
        end
    end

endmodule

// File: rtl/dif_butterfly_pipe.sv
// rtl/dif_butterfly_pipe.sv - 3-stage DIF radix-2 butterfly with scaling and saturation
module dif_butterfly_pipe
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int SCALE      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  inv_i,
    input  logic [DATA_WIDTH-1:0] a_re_i,
    input  logic [DATA_WIDTH-1:0] a_im_i,
    input  logic [DATA_WIDTH-1:0] b_re_i,
    input  logic [DATA_WIDTH-1:0] b_im_i,
    input  logic [DATA_WIDTH-1:0] twid_re_i,
    input  logic [DATA_WIDTH-1:0] twid_im_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] a_re_o,
    output logic [DATA_WIDTH-1:0] a_im_o,
    output logic [DATA_WIDTH-1:0] b_re_o,
    output logic [DATA_WIDTH-1:0] b_im_o,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i
);

    localparam int SW = DATA_WIDTH + 1;
    localparam int PW = 2 * DATA_WIDTH + 2;

    logic en;

    logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;

    logic                  s1_valid, s1_inv;
    logic signed [SW-1:0]  s1_sum_re, s1_sum_im, s1_dif_re, s1_dif_im;
    logic [DATA_WIDTH-1:0] s1_tw_re, s1_tw_im;

    logic                 s2_valid;
    logic signed [SW-1:0] s2_sum_re, s2_sum_im;
    logic [PW-1:0]        s2_prod_re, s2_prod_im;

    acc_t                  a_re_r, a_im_r, b_re_r, b_im_r;
    logic [DATA_WIDTH-1:0] a_re_d, a_im_d, b_re_d, b_im_d;
    logic                  sat_d, out_sat;

    // Whole pipe stalls together only when the output register is full and blocked.
    assign en         = !out_valid_o || out_ready_i;
    assign in_ready_o = en;

    assign a_re = a_re_i;
    assign a_im = a_im_i;
    assign b_re = b_re_i;
    assign b_im = b_im_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid  <= 1'b0;
            s1_inv    <= 1'b0;
            s1_sum_re <= '0;
            s1_sum_im <= '0;
            s1_dif_re <= '0;
            s1_dif_im <= '0;
            s1_tw_re  <= '0;
            s1_tw_im  <= '0;
        end else if (en) begin
            s1_valid  <= in_valid_i;
            s1_inv    <= inv_i;
            s1_sum_re <= SW'(a_re) + SW'(b_re);
            s1_sum_im <= SW'(a_im) + SW'(b_im);
            s1_dif_re <= SW'(a_re) - SW'(b_re);
            s1_dif_im <= SW'(a_im) - SW'(b_im);
            s1_tw_re  <= twid_re_i;
            s1_tw_im  <= twid_im_i;
        end
    end

    cmult_conj #(
        .DW(DATA_WIDTH),
        .XW(SW),
        .PW(PW)
    ) u_cmult (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en),
        .inv_i  (s1_inv),
        .x_re_i (s1_dif_re),
        .x_im_i (s1_dif_im),
        .w_re_i (s1_tw_re),
        .w_im_i (s1_tw_im),
        .p_re_o (s2_prod_re),
        .p_im_o (s2_prod_im)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid  <= 1'b0;
            s2_sum_re <= '0;
            s2_sum_im <= '0;
        end else if (en) begin
            s2_valid  <= s1_valid;
            s2_sum_re <= s1_sum_re;
            s2_sum_im <= s1_sum_im;
        end
    end

    // Products carry FRAC_BITS extra fraction bits from the twiddle.
    always_comb begin
        a_re_r = round_shift(acc_t'(s2_sum_re), SCALE);
        a_im_r = round_shift(acc_t'(s2_sum_im), SCALE);
        b_re_r = round_shift(acc_t'($signed(s2_prod_re)), FRAC_BITS + SCALE);
        b_im_r = round_shift(acc_t'($signed(s2_prod_im)), FRAC_BITS + SCALE);
        sat_d  = sat_hit(a_re_r, DATA_WIDTH) || sat_hit(a_im_r, DATA_WIDTH) ||
                 sat_hit(b_re_r, DATA_WIDTH) || sat_hit(b_im_r, DATA_WIDTH);
        a_re_d = DATA_WIDTH'(saturate(a_re_r, DATA_WIDTH));
        a_im_d = DATA_WIDTH'(saturate(a_im_r, DATA_WIDTH));
        b_re_d = DATA_WIDTH'(saturate(b_re_r, DATA_WIDTH));
        b_im_d = DATA_WIDTH'(saturate(b_im_r, DATA_WIDTH));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_sat     <= 1'b0;
            a_re_o      <= '0;
            a_im_o      <= '0;
            b_re_o      <= '0;
            b_im_o      <= '0;
        end else if (en) begin
            out_valid_o <= s2_valid;
            out_sat     <= sat_d;
            a_re_o      <= a_re_d;
            a_im_o      <= a_im_d;
            b_re_o      <= b_re_d;
            b_im_o      <= b_im_d;
        end
    end

    // Flag a saturated result as it leaves; a same-cycle clear loses to it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_o <= 1'b0;
        end else if (out_valid_o && out_ready_i && out_sat) begin
            ovf_o <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_o <= 1'b0;
        end
    end

endmodule

// File: doc/dif_butterfly_pipe.md
DIF_BUTTERFLY_PIPE -- requirements
Module: dif_butterfly_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 21, is the signed width of all data and twiddle ports, in Q(DATA_WIDTH-FRAC_BITS-1).FRAC_BITS format.
REQ-002 Parameter FRAC_BITS, default 15, is the number of fractional bits.
REQ-003 Parameter SCALE, default 1: when 1, both outputs are divided by 2 (per-stage IFFT scaling); when 0, no scaling.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 in_valid_i  input  1  input operand set valid.
REQ-007 in_ready_o  output  1  block accepts the operand set this cycle.
REQ-008 inv_i  input  1  1 = use conj(W) (inverse transform); sampled with operands.
REQ-009 a_re_i, a_im_i, b_re_i, b_im_i  input  DATA_WIDTH each  operands A and B.
REQ-010 twid_re_i, twid_im_i  input  DATA_WIDTH each  twiddle W.
REQ-011 out_valid_o  output  1  result valid.
REQ-012 out_ready_i  input  1  downstream accepts the result.
REQ-013 a_re_o, a_im_o, b_re_o, b_im_o  output  DATA_WIDTH each  results A', B'.
REQ-014 ovf_o  output  1  sticky saturation flag.
REQ-015 ovf_clr_i  input  1  synchronous clear of ovf_o.

Function
REQ-016 The block SHALL compute the decimation-in-frequency butterfly: A' = (A+B)/s, B' = ((A-B)*Wx)/s, with Wx = W when inv_i=0, conj(W) when inv_i=1, s = 2 if SCALE=1 else 1.
REQ-017 Pipeline of exactly 3 register stages: S1 sum/difference (DATA_WIDTH+1 bits, no overflow), S2 complex multiply (full-precision products), S3 round, shift, saturate; latency from accepted input to out_valid_o = 3 cycles.
REQ-018 Shift amounts: A' by SCALE bits, B' by FRAC_BITS+SCALE bits; rounding is round-half-up (add 2^(shift-1) before arithmetic right shift; no rounding when shift is 0).
REQ-019 Each result SHALL saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; any saturation on a transferred result sets ovf_o on the next edge.
REQ-020 Pipeline advance enable en = !out_valid_o || out_ready_i; all stages (data and valid bits) hold when en=0.
REQ-021 in_ready_o SHALL equal en; an input transfers when in_valid_i && in_ready_o; an output transfers when out_valid_o && out_ready_i.
REQ-022 Full throughput: one transfer per cycle sustained when out_ready_i is held 1; no bubbles inserted.
REQ-023 Outputs SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-024 ovf_clr_i and a new saturation in the same cycle: set wins (ovf_o=1).
REQ-025 Results are delivered in acceptance order; none dropped or duplicated.

Reset
REQ-026 rst_ni low SHALL asynchronously clear all stage valid bits, out_valid_o, ovf_o and all data outputs to 0; in_ready_o=1 during/after reset.
REQ-027 Reset mid-operation discards all in-flight results; the first post-reset output corresponds to the first post-reset accepted input.

Structure
REQ-028 DATA_WIDTH and FRAC_BITS defaults and saturation/round helper functions SHALL live in shared package fft_pkg, shared with the existing butterfly.
REQ-029 The complex multiply with conj select SHALL be sub-module cmult_conj (registered output, enable input), forming stage S2.

Verification (DATA_WIDTH=21, FRAC_BITS=15; 1.0 = 32768)
REQ-030 SCALE=1, W=(30274,-12540), A=(16384,0), B=(16384,0) -> 3 cycles later A'=(16384,0), B'=(0,0), ovf_o=0.
REQ-031 SCALE=0, inv_i=0, W=(0,-32768), A=(32768,0), B=(0,-16384) -> A'=(32768,-16384), B'=(16384,-32768); same with inv_i=1 -> B'=(-16384,32768).
REQ-032 SCALE=0, A=B=(1048575,0), W=(32768,0) -> A'=(1048575,0) saturated, ovf_o=1 next edge; ovf_clr_i pulse -> ovf_o=0.
REQ-033 Stream 8 vectors with out_ready_i toggled pseudo-randomly -> all 8 results in order, outputs stable while stalled, in_ready_o=0 exactly when out_valid_o=1 and out_ready_i=0.
REQ-034 Assert rst_ni low with 2 vectors in flight -> out_valid_o=0 immediately, no stale result after release.
